clk_lock_sequencer: RTL



---
 rtl/clk_lock_sequencer_if.sv | 21 ++
 rtl/clk_lock_sequencer.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/clk_lock_sequencer_if.sv
// Signal bundle between the lock sequencer (master) and the clock wizard / system side (slave).
interface clk_lock_sequencer_if;
  logic       locked;
  logic       force_relock;
  logic       mmcm_reset;
  logic       sys_reset;
  logic       ready;
  logic       fault;
  logic [3:0] retry_count;
  logic [7:0] loss_count;

  modport master (
    input  locked, force_relock,
    output mmcm_reset, sys_reset, ready, fault, retry_count, loss_count
  );

  modport slave (
    output locked, force_relock,
    input  mmcm_reset, sys_reset, ready, fault, retry_count, loss_count
  );
endinterface

// File: rtl/clk_lock_sequencer.sv
// Clock-wizard reset/lock controller: pulses mmcm_reset, waits for a stable lock, then releases sys_reset.
// Optional lock-loss counter enabled by defining CLK_LOCK_LOSS_COUNT_EN.
module clk_lock_sequencer #(
  parameter int unsigned RESET_PULSE_CYCLES  = 4,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 64,
  parameter int unsigned SETTLE_CYCLES       = 8,
  parameter int unsigned MAX_RETRIES         = 2
) (
  input logic                        clk,
  input logic                        reset,
  clk_lock_sequencer_if.master       bus
);

  localparam int unsigned MAX_AB = (RESET_PULSE_CYCLES > LOCK_TIMEOUT_CYCLES) ?
                                   RESET_PULSE_CYCLES : LOCK_TIMEOUT_CYCLES;
  localparam int unsigned MAX_P  = (MAX_AB > SETTLE_CYCLES) ? MAX_AB : SETTLE_CYCLES;
  localparam int unsigned CW     = $clog2(MAX_P + 1);

  localparam logic [CW-1:0] PULSE_LAST   = CW'(RESET_PULSE_CYCLES - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] SETTLE_LAST  = CW'(SETTLE_CYCLES - 1);
  localparam logic [3:0]    RETRY_LAST   = 4'(MAX_RETRIES);

  typedef enum logic [2:0] {
    ST_PULSE     = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_SETTLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAULT     = 3'd4
  } state_e;

  state_e        state_q, state_d, fail_state;
  logic [1:0]    sync_q, sync_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    retry_q, retry_d, fail_retry;
  logic          mmcm_reset_q, mmcm_reset_d;
  logic          sys_reset_q, sys_reset_d;
  logic          ready_q, ready_d;
  logic          fault_q, fault_d;
  logic          locked_s;

  assign locked_s = sync_q[1];

  // Next state, phase counter, retry bookkeeping and state-decoded outputs.
  always_comb begin
    sync_d     = {sync_q[0], bus.locked};
    state_d    = state_q;
    cnt_d      = cnt_q;
    retry_d    = retry_q;
    fail_state = (retry_q == RETRY_LAST) ? ST_FAULT : ST_PULSE;
    fail_retry = (retry_q == RETRY_LAST) ? retry_q : retry_q + 4'd1;
    case (state_q)
      ST_PULSE: begin
        if (cnt_q == PULSE_LAST) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = {CW{1'b0}};
        end else begin
          cnt_d   = cnt_q + 1'b1;
        end
      end
      ST_WAIT_LOCK: begin
        if (locked_s) begin
          state_d = ST_SETTLE;
          cnt_d   = {CW{1'b0}};
        end else if (cnt_q == TIMEOUT_LAST) begin
          state_d = fail_state;
          retry_d = fail_retry;
          cnt_d   = {CW{1'b0}};
        end else begin
          cnt_d   = cnt_q + 1'b1;
        end
      end
      ST_SETTLE: begin
        if (!locked_s) begin
          state_d = fail_state;
          retry_d = fail_retry;
          cnt_d   = {CW{1'b0}};
        end else if (cnt_q == SETTLE_LAST) begin
          state_d = ST_RUN;
          cnt_d   = {CW{1'b0}};
        end else begin
          cnt_d   = cnt_q + 1'b1;
        end
      end
      ST_RUN: begin
        // Loss and force_relock collapse into the same single relock transition.
        if (!locked_s || bus.force_relock) begin
          state_d = ST_PULSE;
          retry_d = 4'd0;
          cnt_d   = {CW{1'b0}};
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_FAULT: begin
        if (bus.force_relock) begin
          state_d = ST_PULSE;
          retry_d = 4'd0;
          cnt_d   = {CW{1'b0}};
        end else begin
          state_d = ST_FAULT;
        end
      end
      default: begin
        state_d = ST_PULSE;
        retry_d = 4'd0;
        cnt_d   = {CW{1'b0}};
      end
    endcase
    mmcm_reset_d = (state_q == ST_PULSE);
    sys_reset_d  = (state_q != ST_RUN);
    ready_d      = (state_q == ST_RUN);
    fault_d      = (state_q == ST_FAULT);
  end

  // Synchronizer, FSM state, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q       <= 2'b00;
      state_q      <= ST_PULSE;
      cnt_q        <= {CW{1'b0}};
      retry_q      <= 4'd0;
      mmcm_reset_q <= 1'b1;
      sys_reset_q  <= 1'b1;
      ready_q      <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      sync_q       <= sync_d;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      retry_q      <= retry_d;
      mmcm_reset_q <= mmcm_reset_d;
      sys_reset_q  <= sys_reset_d;
      ready_q      <= ready_d;
      fault_q      <= fault_d;
    end
  end

  assign bus.mmcm_reset  = mmcm_reset_q;
  assign bus.sys_reset   = sys_reset_q;
  assign bus.ready       = ready_q;
  assign bus.fault       = fault_q;
  assign bus.retry_count = retry_q;

`ifdef CLK_LOCK_LOSS_COUNT_EN
  logic [7:0] loss_count_q, loss_count_d;
  logic       lock_loss;

  assign lock_loss = (state_q == ST_RUN) && !locked_s;

  // Saturating lock-loss event counter.
  always_comb begin
    if (lock_loss && (loss_count_q != 8'hFF)) begin
      loss_count_d = loss_count_q + 8'd1;
    end else begin
      loss_count_d = loss_count_q;
    end
  end

  // Loss counter register, cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      loss_count_q <= 8'd0;
    end else begin
      loss_count_q <= loss_count_d;
    end
  end

  assign bus.loss_count = loss_count_q;
`else
  assign bus.loss_count = 8'd0;
`endif

endmodule
